// File: rtl/song_box_pkg.sv
// Shared song-box definitions used by song_reader, note_player and frequency_rom.
// Holds the note, duration, step and phase widths and the playback state type.
package song_box_pkg;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int STEP_W  = 20;
    localparam int PHASE_W = 22;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } play_state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// frequency_rom: combinational note-index to phase-increment table.
// Ports:
//   addr - note index (0 = rest)
//   step - phase increment per sample for a 22-bit accumulator at 48 kHz
// Entry n holds round(440 * 2^((n-49)/12) * 2^22 / 48000), so note 49 is A4.
// Entry 0 is silence.
module frequency_rom
    import song_box_pkg::*;
(
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] step
);

    always_comb begin
        step = '0;
        case (addr)
            6'd0:  step = 20'd0;
            6'd1:  step = 20'd2403;
            6'd2:  step = 20'd2546;
            6'd3:  step = 20'd2697;
            6'd4:  step = 20'd2858;
            6'd5:  step = 20'd3028;
            6'd6:  step = 20'd3208;
            6'd7:  step = 20'd3398;
            6'd8:  step = 20'd3600;
            6'd9:  step = 20'd3815;
            6'd10: step = 20'd4041;
            6'd11: step = 20'd4282;
            6'd12: step = 20'd4536;
            6'd13: step = 20'd4806;
            6'd14: step = 20'd5092;
            6'd15: step = 20'd5395;
            6'd16: step = 20'd5715;
            6'd17: step = 20'd6055;
            6'd18: step = 20'd6415;
            6'd19: step = 20'd6797;
            6'd20: step = 20'd7201;
            6'd21: step = 20'd7629;
            6'd22: step = 20'd8083;
            6'd23: step = 20'd8563;
            6'd24: step = 20'd9072;
            6'd25: step = 20'd9612;
            6'd26: step = 20'd10184;
            6'd27: step = 20'd10789;
            6'd28: step = 20'd11431;
            6'd29: step = 20'd12110;
            6'd30: step = 20'd12830;
            6'd31: step = 20'd13593;
            6'd32: step = 20'd14402;
            6'd33: step = 20'd15258;
            6'd34: step = 20'd16165;
            6'd35: step = 20'd17127;
            6'd36: step = 20'd18145;
            6'd37: step = 20'd19224;
            6'd38: step = 20'd20367;
            6'd39: step = 20'd21578;
            6'd40: step = 20'd22861;
            6'd41: step = 20'd24221;
            6'd42: step = 20'd25661;
            6'd43: step = 20'd27187;
            6'd44: step = 20'd28803;
            6'd45: step = 20'd30516;
            6'd46: step = 20'd32331;
            6'd47: step = 20'd34253;
            6'd48: step = 20'd36290;
            6'd49: step = 20'd38448;
            6'd50: step = 20'd40734;
            6'd51: step = 20'd43156;
            6'd52: step = 20'd45722;
            6'd53: step = 20'd48441;
            6'd54: step = 20'd51322;
            6'd55: step = 20'd54373;
            6'd56: step = 20'd57607;
            6'd57: step = 20'd61032;
            6'd58: step = 20'd64661;
            6'd59: step = 20'd68506;
            6'd60: step = 20'd72580;
            6'd61: step = 20'd76896;
            6'd62: step = 20'd81468;
            6'd63: step = 20'd86312;
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// note_player: plays one note at a time from song_reader.
// It counts the note's beats down, advances the phase accumulator on each sample
// tick and reports when the note finishes.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   play          - playback enable; low pauses beat counting and phase, output silent
//   note/duration - note index (0 = rest) and length in beats, latched on new_note
//   new_note      - strobe that loads a note and restarts playback
//   beat          - tempo tick
//   sample_tick   - sample-rate strobe
//   note_done     - one-cycle pulse when a note completes
//   busy          - a note is loaded and unfinished
//   step_size     - phase increment of the sounding note, 0 when silent
//   phase         - phase accumulator
//   sample_valid  - pulses in the cycle after each phase update
module note_player
    import song_box_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    input  logic               new_note,
    input  logic               beat,
    input  logic               sample_tick,
    output logic               note_done,
    output logic               busy,
    output logic [STEP_W-1:0]  step_size,
    output logic [PHASE_W-1:0] phase,
    output logic               sample_valid
);

    play_state_t       state;
    logic [DUR_W-1:0]  remaining;
    logic [NOTE_W-1:0] note_q;
    logic [STEP_W-1:0] rom_step;
    logic              active;
    logic              final_beat;
    logic              advance;

    frequency_rom u_frequency_rom (
        .addr (note_q),
        .step (rom_step)
    );

    // Pausing is PLAYING with play low: everything freezes and the output is silent.
    assign active     = (state == PLAYING) && play;
    assign step_size  = active ? rom_step : '0;
    assign final_beat = active && beat && (remaining == DUR_W'(1));
    // A new note restarts the phase at zero, so a coincident sample tick is dropped.
    assign advance    = active && sample_tick && !new_note;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            note_q       <= '0;
            phase        <= '0;
            note_done    <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            note_done    <= 1'b0;
            sample_valid <= advance;

            if (advance) begin
                phase <= phase + PHASE_W'(step_size);
            end

            if (new_note) begin
                note_q    <= note;
                remaining <= duration;
                phase     <= '0;
                if (duration == '0) begin
                    // Zero-length note completes immediately without ever playing.
                    state     <= IDLE;
                    busy      <= 1'b0;
                    note_done <= 1'b1;
                end else begin
                    // An abandoned note is silent unless this cycle also held its last beat.
                    state     <= PLAYING;
                    busy      <= 1'b1;
                    note_done <= final_beat;
                end
            end else if (active && beat) begin
                remaining <= remaining - DUR_W'(1);
                if (final_beat) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    note_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    logic        clk;
    logic        reset;
    logic        play;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        beat;
    logic        sample_tick;
    logic        note_done;
    logic        busy;
    logic [19:0] step_size;
    logic [21:0] phase;
    logic        sample_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: beats left in the current note (0 = nothing playing),
    // the note sounding, the phase, and the pulses expected after the next edge.
    int    m_left  = 0;
    int    m_note  = 0;
    longint m_phase = 0;
    bit    exp_done = 0;
    bit    exp_sv   = 0;

    localparam longint PH_MOD = 64'd4194304;

    note_player dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .beat         (beat),
        .sample_tick  (sample_tick),
        .note_done    (note_done),
        .busy         (busy),
        .step_size    (step_size),
        .phase        (phase),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Equal-tempered pitch, A4 = 440 Hz at note 49, 22-bit phase at 48 kHz.
    function automatic int ref_step(int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * $pow(2.0, (n - 49) / 12.0);
        return $rtoi(f * 4194304.0 / 48000.0 + 0.5);
    endfunction

    function automatic logic [19:0] exp_step();
        return (m_left > 0 && play) ? 20'(ref_step(m_note)) : 20'd0;
    endfunction

    task automatic model_advance();
        bit fin;
        exp_done = 0;
        exp_sv   = 0;
        if (reset) begin
            m_left  = 0;
            m_note  = 0;
            m_phase = 0;
            return;
        end
        fin = (m_left == 1) && play && beat;
        if (m_left > 0 && play && sample_tick && !new_note) begin
            m_phase = (m_phase + ref_step(m_note)) % PH_MOD;
            exp_sv  = 1;
        end
        if (new_note) begin
            exp_done = fin || (duration == 0);
            m_note   = int'(note);
            m_left   = int'(duration);
            m_phase  = 0;
        end else if (m_left > 0 && play && beat) begin
            m_left = m_left - 1;
            if (m_left == 0) exp_done = 1;
        end
    endtask

    // Advance one clock; outputs are then stable for sampling and strobes are cleared.
    task automatic clk_step();
        model_advance();
        @(posedge clk);
        #1;
        new_note    = 1'b0;
        beat        = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; new_note = 1'b1; note = 6'd49; duration = 6'd3;
        beat = 1'b1; sample_tick = 1'b1; play = 1'b1;
        clk_step();
        reset = 1'b0;
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL reset_note_done got %0b want 0", note_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL reset_step got %0d want 0", step_size); end
        checks++; if (phase !== 22'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sample_valid got %0b want 0", sample_valid); end
    endtask

    task automatic test_basic();
        bit want;
        new_note = 1'b1; note = 6'd49; duration = 6'd3; play = 1'b1;
        clk_step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %0b want 1", busy); end
        checks++; if (step_size !== 20'd38448) begin errors++; $display("FAIL basic_step got %0d want 38448", step_size); end
        for (int b = 1; b <= 3; b++) begin
            beat = 1'b1;
            clk_step();
            want = (b == 3);
            checks++; if (note_done !== want) begin errors++; $display("FAIL basic_done_beat%0d got %0b want %0b", b, note_done, want); end
            checks++; if (busy !== !want) begin errors++; $display("FAIL basic_busy_beat%0d got %0b want %0b", b, busy, !want); end
            clk_step();
            checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL basic_done_gap%0d got %0b want 0", b, note_done); end
        end
    endtask

    task automatic test_pause();
        int n;
        n = $urandom_range(1, 63);
        new_note = 1'b1; note = 6'(n); duration = 6'd2; play = 1'b0;
        clk_step();
        for (int b = 0; b < 4; b++) begin
            beat = 1'b1;
            clk_step();
            checks++; if (note_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pause_beat%0d got done=%0b busy=%0b want done=0 busy=1", b, note_done, busy); end
            checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL pause_step got %0d want 0", step_size); end
        end
        play = 1'b1;
        #1;
        checks++; if (step_size !== 20'(ref_step(n))) begin errors++; $display("FAIL pause_resume_step got %0d want %0d", step_size, ref_step(n)); end
        beat = 1'b1;
        clk_step();
        checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL pause_early_done got %0b want 0", note_done); end
        beat = 1'b1;
        clk_step();
        checks++; if (note_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL pause_final got done=%0b busy=%0b want done=1 busy=0", note_done, busy); end
    endtask

    task automatic test_zero_len();
        new_note = 1'b1; note = 6'd20; duration = 6'd0; play = 1'b1;
        clk_step();
        checks++; if (note_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_len got done=%0b busy=%0b want done=1 busy=0", note_done, busy); end
        clk_step();
        checks++; if (note_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_len_after got done=%0b busy=%0b want 0 0", note_done, busy); end
    endtask

    task automatic test_restart();
        bit want;
        new_note = 1'b1; note = 6'd30; duration = 6'd5; play = 1'b1;
        clk_step();
        for (int b = 0; b < 2; b++) begin beat = 1'b1; clk_step(); end
        new_note = 1'b1; note = 6'd40; duration = 6'd3;
        clk_step();
        checks++; if (note_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_switch got done=%0b busy=%0b want 0 1", note_done, busy); end
        checks++; if (step_size !== 20'(ref_step(40))) begin errors++; $display("FAIL restart_step got %0d want %0d", step_size, ref_step(40)); end
        for (int b = 1; b <= 3; b++) begin
            beat = 1'b1;
            clk_step();
            want = (b == 3);
            checks++; if (note_done !== want) begin errors++; $display("FAIL restart_beat%0d got %0b want %0b", b, note_done, want); end
        end
        // New note arriving with the final beat of the old one.
        new_note = 1'b1; note = 6'd10; duration = 6'd1;
        clk_step();
        beat = 1'b1; new_note = 1'b1; note = 6'd12; duration = 6'd2;
        clk_step();
        checks++; if (note_done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL coincide got done=%0b busy=%0b want 1 1", note_done, busy); end
        checks++; if (step_size !== 20'(ref_step(12))) begin errors++; $display("FAIL coincide_step got %0d want %0d", step_size, ref_step(12)); end
        for (int b = 0; b < 2; b++) begin beat = 1'b1; clk_step(); end
        checks++; if (note_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL coincide_end got done=%0b busy=%0b want 1 0", note_done, busy); end
    endtask

    task automatic test_rest();
        new_note = 1'b1; note = 6'd0; duration = 6'd1; play = 1'b1;
        clk_step();
        for (int t = 0; t < 4; t++) begin
            sample_tick = 1'b1;
            clk_step();
            checks++; if (step_size !== 20'd0 || phase !== 22'd0) begin errors++; $display("FAIL rest_tick%0d got step=%0d phase=%0d want 0 0", t, step_size, phase); end
        end
        beat = 1'b1;
        clk_step();
        checks++; if (note_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rest_done got done=%0b busy=%0b want 1 0", note_done, busy); end
    endtask

    task automatic test_phase();
        longint want;
        new_note = 1'b1; note = 6'd49; duration = 6'd10; play = 1'b1;
        clk_step();
        for (int t = 0; t < 10; t++) begin
            sample_tick = 1'b1;
            clk_step();
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL phase_sv_tick%0d got %0b want 1", t, sample_valid); end
            clk_step();
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL phase_sv_gap%0d got %0b want 0", t, sample_valid); end
        end
        want = (10 * longint'(ref_step(49))) % PH_MOD;
        checks++; if (phase !== 22'(want)) begin errors++; $display("FAIL phase_10_ticks got %0d want %0d", phase, want); end
        reset = 1'b1; beat = 1'b1; sample_tick = 1'b1; new_note = 1'b1; note = 6'd5; duration = 6'd1;
        clk_step();
        reset = 1'b0;
        checks++; if (note_done !== 1'b0 || busy !== 1'b0 || step_size !== 20'd0 || phase !== 22'd0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got done=%0b busy=%0b step=%0d phase=%0d sv=%0b want all 0", note_done, busy, step_size, phase, sample_valid);
        end
        for (int c = 0; c < 3; c++) begin
            beat = 1'b1; sample_tick = 1'b1;
            clk_step();
            checks++; if (note_done !== 1'b0 || phase !== 22'd0) begin errors++; $display("FAIL post_reset%0d got done=%0b phase=%0d want 0 0", c, note_done, phase); end
        end
    endtask

    task automatic test_wrap();
        longint want;
        new_note = 1'b1; note = 6'd63; duration = 6'd1; play = 1'b1;
        clk_step();
        for (int t = 0; t < 60; t++) begin sample_tick = 1'b1; clk_step(); end
        want = (60 * longint'(ref_step(63))) % PH_MOD;
        checks++; if (phase !== 22'(want)) begin errors++; $display("FAIL wrap_phase got %0d want %0d", phase, want); end
        beat = 1'b1;
        clk_step();
        checks++; if (note_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b want 1", note_done); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 399) == 0);
            play        = ($urandom_range(0, 9) != 0);
            new_note    = ($urandom_range(0, 14) == 0);
            note        = 6'($urandom_range(0, 63));
            duration    = 6'($urandom_range(0, 6));
            beat        = ($urandom_range(0, 2) == 0);
            sample_tick = ($urandom_range(0, 1) == 0);
            clk_step();
            reset = 1'b0;
            play  = ($urandom_range(0, 9) != 0);
            #1;
            checks++; if (note_done !== exp_done) begin errors++; $display("FAIL rand_done c=%0d got %0b want %0b", c, note_done, exp_done); end
            checks++; if (busy !== (m_left > 0)) begin errors++; $display("FAIL rand_busy c=%0d got %0b want %0b", c, busy, m_left > 0); end
            checks++; if (step_size !== exp_step()) begin errors++; $display("FAIL rand_step c=%0d got %0d want %0d", c, step_size, exp_step()); end
            checks++; if (phase !== 22'(m_phase)) begin errors++; $display("FAIL rand_phase c=%0d got %0d want %0d", c, phase, m_phase); end
            checks++; if (sample_valid !== exp_sv) begin errors++; $display("FAIL rand_sv c=%0d got %0b want %0b", c, sample_valid, exp_sv); end
        end
    endtask

    initial begin
        reset = 1'b0; play = 1'b0; note = '0; duration = '0;
        new_note = 1'b0; beat = 1'b0; sample_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_pause();
        test_zero_len();
        test_restart();
        test_rest();
        test_phase();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
